// File: rtl/hex_entry_pkg.sv
// Shared types for the hex entry front end: button identities (enum order is event priority),
// widths, and the priority pick helper.
package hex_entry_pkg;

    localparam int unsigned NUM_BTNS   = 5;
    localparam int unsigned VALUE_W    = 32;
    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned CURSOR_W   = 3;
    localparam int unsigned NIBBLE_W   = 4;

    // Lower encoding wins when several press events land in the same cycle.
    typedef enum logic [2:0] {
        BTN_CENTER = 3'd0,
        BTN_UP     = 3'd1,
        BTN_DOWN   = 3'd2,
        BTN_LEFT   = 3'd3,
        BTN_RIGHT  = 3'd4
    } btn_e;

    function automatic btn_e pick_event(input logic [NUM_BTNS-1:0] ev);
        btn_e sel;
        sel = BTN_RIGHT;
        for (int i = int'(NUM_BTNS) - 1; i >= 0; i--) begin
            if (ev[i]) sel = btn_e'(3'(i));
        end
        return sel;
    endfunction

endpackage

// File: rtl/hex_entry_if.sv
// Button, host-load and display bundle between the board/host side and hex_entry.
interface hex_entry_if;
    import hex_entry_pkg::*;

    logic                btn_up;
    logic                btn_down;
    logic                btn_left;
    logic                btn_right;
    logic                btn_center;
    logic                load;
    logic [VALUE_W-1:0]  load_value;
    logic [VALUE_W-1:0]  value;
    logic [VALUE_W-1:0]  committed;
    logic                commit;
    logic [CURSOR_W-1:0] cursor;
    logic [NUM_DIGITS-1:0] enable;

    modport master (
        output btn_up, btn_down, btn_left, btn_right, btn_center, load, load_value,
        input  value, committed, commit, cursor, enable
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, btn_center, load, load_value,
        output value, committed, commit, cursor, enable
    );
endinterface

// File: rtl/hex_entry_button_debounce.sv
// One push-button: 2-flop synchronizer, stability counter and registered rising-edge press pulse.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             level_prev_q, level_prev_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d      = raw;
        sync2_d      = sync1_q;
        level_d      = level_q;
        cnt_d        = '0;
        level_prev_d = level_q;
        press_d      = level_q & ~level_prev_q;
        // Count only while the synchronized input disagrees; any agreement restarts the window.
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            press_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            level_q      <= level_d;
            level_prev_q <= level_prev_d;
            press_q      <= press_d;
            cnt_q        <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;
endmodule

// File: rtl/hex_entry.sv
// Debounced five-button hex editor: nibble/cursor edits, commit capture, host load and cursor blink.
module hex_entry
    import hex_entry_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter int unsigned BLINK_CYCLES    = 4000000
) (
    input  logic        clk,
    input  logic        reset,
    hex_entry_if.slave  bus
);
    localparam int unsigned BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    logic [NUM_BTNS-1:0]   raw, level, press, evt;
    logic [VALUE_W-1:0]    value_q, value_d;
    logic [VALUE_W-1:0]    committed_q, committed_d;
    logic                  commit_q, commit_d;
    logic [CURSOR_W-1:0]   cursor_q, cursor_d;
    logic [NUM_DIGITS-1:0] enable_q, enable_d;
    logic                  blink_on_q, blink_on_d;
    logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;
    logic [4:0]            nib_lsb;
    btn_e                  sel;

    // Bit index follows btn_e encoding.
    assign raw = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up, bus.btn_center};

    for (genvar g = 0; g < int'(NUM_BTNS); g++) begin : g_btn
        button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
            .clk   (clk),
            .reset (reset),
            .raw   (raw[g]),
            .level (level[g]),
            .press (press[g])
        );
    end

    // A press whose level has already fallen again is ignored.
    assign evt     = press & level;
    assign sel     = pick_event(evt);
    assign nib_lsb = {cursor_q, 2'b00};

    always_comb begin
        value_d     = value_q;
        committed_d = committed_q;
        commit_d    = 1'b0;
        cursor_d    = cursor_q;
        blink_on_d  = blink_on_q;
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);

        if (bus.load) begin
            value_d = bus.load_value;
        end else if (|evt) begin
            unique case (sel)
                BTN_CENTER: begin
                    committed_d = value_q;
                    commit_d    = 1'b1;
                end
                BTN_UP:   value_d[nib_lsb +: NIBBLE_W] = value_q[nib_lsb +: NIBBLE_W] + 4'd1;
                BTN_DOWN: value_d[nib_lsb +: NIBBLE_W] = value_q[nib_lsb +: NIBBLE_W] - 4'd1;
                BTN_LEFT: cursor_d = cursor_q + 3'd1;
                default:  cursor_d = cursor_q - 3'd1;
            endcase
        end

        // Any press restarts a full on-phase so the operator sees the digit immediately.
        if (|evt) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_on_d  = ~blink_on_q;
        end

        enable_d           = '1;
        enable_d[cursor_q] = blink_on_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q     <= '0;
            committed_q <= '0;
            commit_q    <= 1'b0;
            cursor_q    <= '0;
            enable_q    <= '1;
            blink_on_q  <= 1'b1;
            blink_cnt_q <= '0;
        end else begin
            value_q     <= value_d;
            committed_q <= committed_d;
            commit_q    <= commit_d;
            cursor_q    <= cursor_d;
            enable_q    <= enable_d;
            blink_on_q  <= blink_on_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    assign bus.value     = value_q;
    assign bus.committed = committed_q;
    assign bus.commit    = commit_q;
    assign bus.cursor    = cursor_q;
    assign bus.enable    = enable_q;
endmodule

// File: doc/hex_entry.md
# hex_entry

Board-input front end for the debug display path: reads five raw push-buttons, debounces them, and turns presses into edits of a 32-bit hex value. It drives the same `value`/`enable` pair the seven-segment driver consumes, and blinks the digit under edit. It also issues a one-cycle commit pulse when the operator confirms, so debug logic can capture the entered value, for example as a breakpoint address or a poke value.

## Interface
- `DEBOUNCE_CYCLES`, default 20000: consecutive stable cycles required before a debounced level changes (~1 ms).
- `BLINK_CYCLES`, default 4000000: half-period of the cursor blink, in clocks.
- `clk`  in  1  system clock.
- `reset`  in  1  reset; one clock, synchronous, active-high.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, `btn_center`  in  1 each  raw asynchronous buttons; active-high.
- `load`  in  1  host load strobe.
- `load_value`  in  32  value written into `value` on `load`.
- `value`  out  32  live edit register.
- `committed`  out  32  value captured at the last commit.
- `commit`  out  1  one-cycle pulse on commit.
- `cursor`  out  3  index of the nibble under edit; 0 = bits [3:0].
- `enable`  out  8  per-digit enable for the display.

## Operation
- Per button:
  - A 2-flop synchronizer feeds a debounce counter.
  - The counter increments while the synchronized level differs from the debounced level. It clears on any cycle where they match.
  - When the counter reaches `DEBOUNCE_CYCLES-1` and the levels still differ, the debounced level flips and the counter clears.
  - A press event is a one-cycle pulse on a rising edge of the debounced level.
  - Releases produce no event. There is no auto-repeat.
- Event actions, with nibble arithmetic mod 16 and cursor arithmetic mod 8:
  - up: `value[cursor]` increments (F→0).
  - down: `value[cursor]` decrements (0→F).
  - left: `cursor` increments (7→0).
  - right: `cursor` decrements (0→7).
  - center: `committed <= value`; `commit` pulses.
- Simultaneous events in one cycle: only the highest-priority one acts (center > up > down > left > right). The others are dropped, not queued.
- `load` overrides all button events in the same cycle:
  - `value <= load_value`.
  - `cursor` is unchanged.
  - Any coincident button event is dropped.
- Blink:
  - A free-running counter toggles `blink_on` every `BLINK_CYCLES` clocks.
  - Any press event resets the counter and forces `blink_on = 1`.
  - `enable` is all ones, except that bit `cursor` equals `blink_on`.

## Timing
- Reset values:
  - `value = 0`, `committed = 0`, `cursor = 0`, `commit = 0`, `enable = 8'hFF`.
  - Internal: `blink_on = 1`; synchronizers, debounced levels and counters are all 0.
- Reset asserted mid-debounce or mid-blink discards all partial counts.
- Press latency: counted from the first clock edge at which the raw input is sampled high and then held stable, as 2 (sync) + `DEBOUNCE_CYCLES` (debounce) + 1 (action register) edges. The edit is therefore visible on `value`/`cursor` `DEBOUNCE_CYCLES+3` edges later.
- Bounce rule: a glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no event.
- `commit` is high for exactly one cycle; `committed` updates on the same edge.
- `load` takes effect on the next edge (1-cycle latency).
- `enable` is registered and follows a `cursor` change one edge later.

## Structure
- Package `hex_entry_pkg`:
  - `btn_e` enum (`BTN_CENTER`, `BTN_UP`, `BTN_DOWN`, `BTN_LEFT`, `BTN_RIGHT`).
  - `NUM_BTNS = 5`.
  - Priority order expressed as enum order.
- Sub-module `button_debounce`:
  - Parameter: `DEBOUNCE_CYCLES`.
  - Ports: `clk`, `reset`, `raw`, `level`, `press`.
  - Contains the synchronizer, counter and edge detect.
  - Instantiated `NUM_BTNS` times via generate.
- Top level holds the edit/cursor/commit logic and the blink counter.

## Test plan
Sim parameters: `DEBOUNCE_CYCLES=4`, `BLINK_CYCLES=8`.
- Reset → `value=0`, `committed=0`, `cursor=0`, `commit=0`, `enable=8'hFF`. Hold reset during an active press → no event after release of reset until a fresh debounce completes.
- Bounce filtering:
  - `btn_up` high 10 cycles → `value=32'h00000001` exactly 7 edges after first sampled high.
  - A 2-cycle glitch → no change.
- Nibble and cursor wrap:
  - From 0, `btn_down` → `32'h0000000F`.
  - Then `btn_left`, `btn_up` ×3 → `32'h0000003F`.
  - `btn_right` ×2 → `cursor=7`.
- Simultaneous events:
  - `btn_center` and `btn_up` debounced on the same cycle → `commit` pulses once, `committed=value`, `value` unchanged.
  - `load=1` with `load_value=32'hDEADBEEF` in the same cycle as an up event → `value=32'hDEADBEEF`, up dropped.
- Blink:
  - With `cursor=2`, `enable` alternates `8'hFF`/`8'hFB` every 8 cycles.
  - A press mid-phase → `enable=8'hFF` next edge and a full 8-cycle on-phase follows.
